line_buffer: RTL

LINE_BUFFER -- requirements
Module: line_buffer

---
 rtl/line_buffer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/line_buffer.sv
// line_buffer: turns a raster-order pixel stream into KxK sliding windows
// (valid convolution, stride 1) for a downstream processing element.
// Previous K-1 rows live in per-row line memories; the current KxK
// neighbourhood lives in a column shift register.
module line_buffer #(
    parameter int kernel_size = 2,
    parameter int data_width  = 4,
    parameter int data_height = 4,
    parameter int point_width = 8
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [0:point_width-1]                         pixel_in,
    input  logic                                           pixel_valid,
    output logic [0:point_width*kernel_size*kernel_size-1] window,
    output logic                                           window_valid,
    output logic                                           frame_done
);

    localparam int K        = kernel_size;
    localparam int W        = data_width;
    localparam int H        = data_height;
    localparam int PW       = point_width;
    localparam int WIN_BITS = PW * K * K;
    localparam int CW       = $clog2(W);
    localparam int RW       = $clog2(H);

    localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [0:WIN_BITS-1] r_shift;
    logic [0:WIN_BITS-1] r_window;
    logic                r_window_valid;
    logic                r_frame_done;

    logic [0:WIN_BITS-1] w_shift_next;
    logic                w_win_ok;
    logic                w_col_last;
    logic                w_row_last;

    // Column of K pixels at the current column position, index 0 = oldest
    // row (top of window), index K-1 = the incoming pixel (bottom).
    logic [0:PW-1]       w_col [0:K-1];

    assign w_col[K-1] = pixel_in;

    // Line memory gi holds image row r-1-gi. On each accepted pixel every
    // memory passes its old entry at this column one row further up.
    // Contents are never cleared: the counters keep stale rows out of any
    // window that is flagged valid.
    genvar gi, gj;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_line
            logic [0:PW-1] r_mem [0:W-1];

            // Write the pixel one row below this memory's row into the current column
            always_ff @(posedge clock) begin
                if (!reset && pixel_valid) begin
                    r_mem[r_col] <= w_col[K-1-gi];
                end
            end

            assign w_col[K-2-gi] = r_mem[r_col];
        end

        // Shift the window one column left and insert the fresh column at
        // the right edge (window column K-1).
        for (gi = 0; gi < K; gi++) begin : g_win_row
            for (gj = 0; gj < K; gj++) begin : g_win_col
                if (gj == K - 1) begin : g_new
                    assign w_shift_next[(gi*K+gj)*PW +: PW] = w_col[gi];
                end else begin : g_old
                    assign w_shift_next[(gi*K+gj)*PW +: PW] = r_shift[(gi*K+gj+1)*PW +: PW];
                end
            end
        end
    endgenerate

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    // A full window exists only once K rows and K columns of this frame are in.
    assign w_win_ok   = (r_col >= COL_FIRST) && (r_row >= ROW_FIRST);

    // Raster counters, window shift register and registered window outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_col          <= '0;
            r_row          <= '0;
            r_shift        <= '0;
            r_window       <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            if (pixel_valid) begin
                r_shift <= w_shift_next;
                if (w_win_ok) begin
                    r_window       <= w_shift_next;
                    r_window_valid <= 1'b1;
                    r_frame_done   <= w_row_last && w_col_last;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign window       = r_window;
    assign window_valid = r_window_valid;
    assign frame_done   = r_frame_done;

endmodule
